// File: rtl/decode_execute_register.sv
// Decode/execute pipeline register with load-use bubble insertion,
// branch squash of decode, memory-stall freeze and saturating event counters.
module decode_execute_register #(
  parameter int unsigned CONTROL_WIDTH = 16,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     idValid,
  input  logic [CONTROL_WIDTH-1:0] idControl,
  input  logic [4:0]               idRs,
  input  logic [4:0]               idRt,
  input  logic                     idUsesRs,
  input  logic                     idUsesRt,
  input  logic [4:0]               idWriteAddr,
  input  logic                     idIsLoad,
  input  logic                     exTaken,
  input  logic                     memStall,
  output logic                     exValid,
  output logic [CONTROL_WIDTH-1:0] exControl,
  output logic [4:0]               exRs,
  output logic [4:0]               exRt,
  output logic [4:0]               exWriteAddr,
  output logic                     exIsLoad,
  output logic                     stallFetch,
  output logic                     flushDecode,
  output logic [COUNTER_WIDTH-1:0] loadUseCount,
  output logic [COUNTER_WIDTH-1:0] flushCount
);

  localparam int unsigned REG_W = 5;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

  logic                     valid_q,   valid_d;
  logic [CONTROL_WIDTH-1:0] control_q, control_d;
  logic [REG_W-1:0]         rs_q,      rs_d;
  logic [REG_W-1:0]         rt_q,      rt_d;
  logic [REG_W-1:0]         waddr_q,   waddr_d;
  logic                     is_load_q, is_load_d;
  logic [COUNTER_WIDTH-1:0] lu_cnt_q,  lu_cnt_d;
  logic [COUNTER_WIDTH-1:0] fl_cnt_q,  fl_cnt_d;
  logic                     hazard;
  logic                     rs_match;
  logic                     rt_match;

  // Load-use hazard: decode reads the (non-zero) register a load in execute is producing
  always_comb begin
    rs_match = idUsesRs && (idRs == waddr_q);
    rt_match = idUsesRt && (idRt == waddr_q);
    hazard   = valid_q && is_load_q && (waddr_q != REG_W'(0)) && idValid
               && (rs_match || rt_match);
  end

  // Priority action select: stall > taken-branch flush > load-use bubble > capture
  always_comb begin
    valid_d     = valid_q;
    control_d   = control_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    waddr_d     = waddr_q;
    is_load_d   = is_load_q;
    lu_cnt_d    = lu_cnt_q;
    fl_cnt_d    = fl_cnt_q;
    stallFetch  = 1'b0;
    flushDecode = 1'b0;

    if (memStall) begin
      stallFetch = 1'b1;
    end else if (exTaken || hazard) begin
      valid_d   = 1'b0;
      control_d = '0;
      rs_d      = '0;
      rt_d      = '0;
      waddr_d   = '0;
      is_load_d = 1'b0;
      if (exTaken) begin
        flushDecode = 1'b1;
        fl_cnt_d    = (fl_cnt_q == CNT_MAX) ? fl_cnt_q : fl_cnt_q + COUNTER_WIDTH'(1);
      end else begin
        stallFetch  = 1'b1;
        lu_cnt_d    = (lu_cnt_q == CNT_MAX) ? lu_cnt_q : lu_cnt_q + COUNTER_WIDTH'(1);
      end
    end else begin
      // An invalid slot keeps its fields but carries no control, so it never acts
      valid_d   = idValid;
      control_d = idValid ? idControl : '0;
      rs_d      = idRs;
      rt_d      = idRt;
      waddr_d   = idWriteAddr;
      is_load_d = idIsLoad;
    end
  end

  // Execute-stage state register with synchronous reset to an empty bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      control_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      waddr_q   <= '0;
      is_load_q <= 1'b0;
      lu_cnt_q  <= '0;
      fl_cnt_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      control_q <= control_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      waddr_q   <= waddr_d;
      is_load_q <= is_load_d;
      lu_cnt_q  <= lu_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  assign exValid      = valid_q;
  assign exControl    = control_q;
  assign exRs         = rs_q;
  assign exRt         = rt_q;
  assign exWriteAddr  = waddr_q;
  assign exIsLoad     = is_load_q;
  assign loadUseCount = lu_cnt_q;
  assign flushCount   = fl_cnt_q;

endmodule

// File: tb/tb_decode_execute_register.sv
// Scoreboard bench for decode_execute_register: directed per-cycle vectors with
// hand-derived expectations; a monitor checks combinational and registered outputs.
module tb_decode_execute_register;

  logic        clock;
  logic        reset;
  logic        idValid;
  logic [15:0] idControl;
  logic [4:0]  idRs, idRt, idWriteAddr;
  logic        idUsesRs, idUsesRt, idIsLoad;
  logic        exTaken, memStall;

  logic        exValid;
  logic [15:0] exControl;
  logic [4:0]  exRs, exRt, exWriteAddr;
  logic        exIsLoad, stallFetch, flushDecode;
  logic [15:0] loadUseCount, flushCount;

  logic        n_exValid;
  logic [15:0] n_exControl;
  logic [4:0]  n_exRs, n_exRt, n_exWriteAddr;
  logic        n_exIsLoad, n_stallFetch, n_flushDecode;
  logic [1:0]  n_loadUseCount, n_flushCount;

  decode_execute_register #(.CONTROL_WIDTH(16), .COUNTER_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .idValid(idValid), .idControl(idControl),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idWriteAddr(idWriteAddr), .idIsLoad(idIsLoad), .exTaken(exTaken),
    .memStall(memStall), .exValid(exValid), .exControl(exControl),
    .exRs(exRs), .exRt(exRt), .exWriteAddr(exWriteAddr), .exIsLoad(exIsLoad),
    .stallFetch(stallFetch), .flushDecode(flushDecode),
    .loadUseCount(loadUseCount), .flushCount(flushCount)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation
  decode_execute_register #(.CONTROL_WIDTH(16), .COUNTER_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .idValid(idValid), .idControl(idControl),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idWriteAddr(idWriteAddr), .idIsLoad(idIsLoad), .exTaken(exTaken),
    .memStall(memStall), .exValid(n_exValid), .exControl(n_exControl),
    .exRs(n_exRs), .exRt(n_exRt), .exWriteAddr(n_exWriteAddr), .exIsLoad(n_exIsLoad),
    .stallFetch(n_stallFetch), .flushDecode(n_flushDecode),
    .loadUseCount(n_loadUseCount), .flushCount(n_flushCount)
  );

  typedef struct {
    logic        rst, ms, tk, iv;
    logic [15:0] ctl;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [4:0]  wa;
    logic        ld;
    logic        cc, es, ef, ev;
    logic [15:0] ectl;
    logic [4:0]  ers, ert, ewa;
    logic        eld;
    logic [15:0] luc, fc;
    logic [1:0]  lucn;
  } vec_t;

  vec_t stim[$];
  vec_t sb[$];
  vec_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic in_v(input logic rst, input logic ms, input logic tk, input logic iv,
                      input logic [15:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] wa, input logic ld);
    cur.rst = rst; cur.ms = ms; cur.tk = tk; cur.iv = iv; cur.ctl = ctl;
    cur.rs = rs; cur.rt = rt; cur.urs = urs; cur.urt = urt; cur.wa = wa; cur.ld = ld;
  endtask

  task automatic ex_v(input logic cc, input logic es, input logic ef, input logic ev,
                      input logic [15:0] ectl, input logic [4:0] ers, input logic [4:0] ert,
                      input logic [4:0] ewa, input logic eld, input logic [15:0] luc,
                      input logic [15:0] fc, input logic [1:0] lucn);
    cur.cc = cc; cur.es = es; cur.ef = ef; cur.ev = ev; cur.ectl = ectl;
    cur.ers = ers; cur.ert = ert; cur.ewa = ewa; cur.eld = eld;
    cur.luc = luc; cur.fc = fc; cur.lucn = lucn;
    stim.push_back(cur);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs just after the edge
  initial begin
    vec_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0 && sb[0].cc) begin
        chk("stallFetch",  32'(stallFetch),  32'(sb[0].es));
        chk("flushDecode", 32'(flushDecode), 32'(sb[0].ef));
      end
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("exValid",        32'(exValid),        32'(e.ev));
        chk("exControl",      32'(exControl),      32'(e.ectl));
        chk("exRs",           32'(exRs),           32'(e.ers));
        chk("exRt",           32'(exRt),           32'(e.ert));
        chk("exWriteAddr",    32'(exWriteAddr),    32'(e.ewa));
        chk("exIsLoad",       32'(exIsLoad),       32'(e.eld));
        chk("loadUseCount",   32'(loadUseCount),   32'(e.luc));
        chk("flushCount",     32'(flushCount),     32'(e.fc));
        chk("satLoadUseCount", 32'(n_loadUseCount), 32'(e.lucn));
      end
    end
  end

  // Driver: one vector per clock, expectation pushed as the vector is applied
  initial begin
    logic [1:0] sat [0:5];
    int         wait_cyc;
    sat[0] = 2'd0; sat[1] = 2'd1; sat[2] = 2'd2; sat[3] = 2'd3; sat[4] = 2'd3; sat[5] = 2'd3;

    // Reset for two cycles with a live instruction at decode
    in_v(1,0,0,1,16'h00A5,0,0,0,0,8,0); ex_v(0,0,0,0,16'h0000,0,0,0,0,0,0,0);
    in_v(1,0,0,1,16'h00A5,0,0,0,0,8,0); ex_v(1,0,0,0,16'h0000,0,0,0,0,0,0,0);
    // First capture after reset release
    in_v(0,0,0,1,16'h00A5,1,2,1,1,8,0); ex_v(1,0,0,1,16'h00A5,1,2,8,0,0,0,0);
    // Load r8, then dependent on rs: one bubble, then capture
    in_v(0,0,0,1,16'h0011,3,4,1,1,8,1); ex_v(1,0,0,1,16'h0011,3,4,8,1,0,0,0);
    in_v(0,0,0,1,16'h0022,8,5,1,0,9,0); ex_v(1,1,0,0,16'h0000,0,0,0,0,1,0,1);
    in_v(0,0,0,1,16'h0022,8,5,1,0,9,0); ex_v(1,0,0,1,16'h0022,8,5,9,0,1,0,1);
    // Load to r0 followed by reader of r0: no hazard
    in_v(0,0,0,1,16'h0033,1,2,1,1,0,1); ex_v(1,0,0,1,16'h0033,1,2,0,1,1,0,1);
    in_v(0,0,0,1,16'h0044,0,0,1,1,10,0); ex_v(1,0,0,1,16'h0044,0,0,10,0,1,0,1);
    // Load r8 followed by an instruction naming r8 but not reading it
    in_v(0,0,0,1,16'h0055,1,2,1,1,8,1); ex_v(1,0,0,1,16'h0055,1,2,8,1,1,0,1);
    in_v(0,0,0,1,16'h0066,8,8,0,0,11,0); ex_v(1,0,0,1,16'h0066,8,8,11,0,1,0,1);
    // Load r12 followed by a reader on rt
    in_v(0,0,0,1,16'h0077,1,2,1,1,12,1); ex_v(1,0,0,1,16'h0077,1,2,12,1,1,0,1);
    in_v(0,0,0,1,16'h0088,3,12,1,1,13,0); ex_v(1,1,0,0,16'h0000,0,0,0,0,2,0,2);
    in_v(0,0,0,1,16'h0088,3,12,1,1,13,0); ex_v(1,0,0,1,16'h0088,3,12,13,0,2,0,2);
    // Reset clears counters
    in_v(1,0,0,0,16'h0000,0,0,0,0,0,0); ex_v(1,0,0,0,16'h0000,0,0,0,0,0,0,0);
    // Taken branch beats a load-use hazard
    in_v(0,0,0,1,16'h0099,1,2,1,1,8,1); ex_v(1,0,0,1,16'h0099,1,2,8,1,0,0,0);
    in_v(0,0,1,1,16'h00AA,8,0,1,0,3,0); ex_v(1,0,1,0,16'h0000,0,0,0,0,0,1,0);
    in_v(0,0,0,1,16'h00AA,8,0,1,0,3,0); ex_v(1,0,0,1,16'h00AA,8,0,3,0,0,1,0);
    // Memory stall for three cycles with exTaken held: everything frozen
    in_v(0,1,1,1,16'h00BB,4,5,1,1,6,1); ex_v(1,1,0,1,16'h00AA,8,0,3,0,0,1,0);
    in_v(0,1,1,1,16'h00CC,7,8,1,1,9,0); ex_v(1,1,0,1,16'h00AA,8,0,3,0,0,1,0);
    in_v(0,1,1,0,16'h00DD,3,3,1,1,8,1); ex_v(1,1,0,1,16'h00AA,8,0,3,0,0,1,0);
    // Stall drops: the held branch now flushes for one cycle
    in_v(0,0,1,1,16'h00EE,1,1,1,1,2,0); ex_v(1,0,1,0,16'h0000,0,0,0,0,0,2,0);
    in_v(0,0,0,1,16'h00EE,1,1,1,1,2,0); ex_v(1,0,0,1,16'h00EE,1,1,2,0,0,2,0);
    // Invalid capture keeps fields but no valid/control; it cannot cause a hazard
    in_v(0,0,0,0,16'h00F0,9,10,1,1,11,1); ex_v(1,0,0,0,16'h0000,9,10,11,1,0,2,0);
    in_v(0,0,0,1,16'h0101,11,0,1,0,1,0); ex_v(1,0,0,1,16'h0101,11,0,1,0,0,2,0);
    // Self-dependent load r8 held at decode: alternating capture and bubble
    in_v(0,0,0,1,16'h0123,8,0,1,0,8,1);
    for (int k = 1; k <= 5; k++) begin
      ex_v(1,0,0,1,16'h0123,8,0,8,1,16'(k-1),2,sat[k-1]);
      ex_v(1,1,0,0,16'h0000,0,0,0,0,16'(k),2,sat[k]);
    end
    ex_v(1,0,0,1,16'h0123,8,0,8,1,5,2,sat[5]);
    // Reset asserted during a memory stall with a branch pending
    in_v(1,1,1,1,16'h0123,8,0,1,0,8,1); ex_v(0,0,0,0,16'h0000,0,0,0,0,0,0,0);
    in_v(0,0,0,0,16'h0000,0,0,0,0,0,0); ex_v(1,0,0,0,16'h0000,0,0,0,0,0,0,0);

    foreach (stim[i]) begin
      reset       = stim[i].rst;
      memStall    = stim[i].ms;
      exTaken     = stim[i].tk;
      idValid     = stim[i].iv;
      idControl   = stim[i].ctl;
      idRs        = stim[i].rs;
      idRt        = stim[i].rt;
      idUsesRs    = stim[i].urs;
      idUsesRt    = stim[i].urt;
      idWriteAddr = stim[i].wa;
      idIsLoad    = stim[i].ld;
      sb.push_back(stim[i]);
      @(posedge clock);
      #2;
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clock);
      #2;
      wait_cyc++;
    end
    chk("scoreboardDrained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
